pixel_send: RTL and testbench
=============================

PIXEL_SEND -- requirements
Module: pixel_send

Interface
REQ-001 Parameter X_LEN, default 11, width of Nx and x counter.
REQ-002 Parameter Y_LEN, default 5, width of Ny and y counter.
REQ-003 Parameter Z_LEN, default 8, width of Nz and z counter.
REQ-004 Parameter DATA_WIDTH, default 12, significant sample bits; packed fields zero-extended to 16.
REQ-005 Parameter LINE_DEPTH, default 2048, line-RAM entries; Nx*Nz must not exceed it.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start_i  in  1  one-cycle frame start pulse; samples Nx/Ny/Nz.
REQ-009 Nx / Ny / Nz  in  X_LEN / Y_LEN / Z_LEN  frame dimensions, each >=1.
REQ-010 pix_i  in  DATA_WIDTH  raw sample, order x fastest, then z, then y.
REQ-011 pix_valid_i  in  1  pix_i valid.
REQ-012 pix_ready_o  out  1  block accepts pix_i this cycle.
REQ-013 data_o  out  32  packed word {Sne[31:16], S[15:0]}.
REQ-014 en_o  out  1  data_o valid, one word per cycle max.
REQ-015 busy_o / done_o / cfg_err_o  out  1 each  frame active / one-cycle end-of-frame pulse / start rejected.

Function
REQ-016 FSM states IDLE, RUN; reset state IDLE.
REQ-017 IDLE->RUN on start_i when 1<=Nx*Nz<=LINE_DEPTH and Ny>=1; otherwise stay IDLE and pulse cfg_err_o one cycle.
REQ-018 Nx, Ny, Nz registered on accepted start_i; input changes during RUN ignored.
REQ-019 pix_ready_o SHALL be 1 exactly in RUN; a transfer occurs when pix_valid_i & pix_ready_o.
REQ-020 Counters x (0..Nx-1), z (0..Nz-1), y (0..Ny-1) advance only on transfer; x wraps -> z++, z wraps -> y++.
REQ-021 Line address addr = z*Nx + x, maintained incrementally (increment per transfer, clear on row-of-frame wrap), no multiplier.
REQ-022 On each transfer: write pix_i to line RAM at addr; read RAM at addr+1 in the same cycle (read-before-write, distinct addresses).
REQ-023 Latency: transfer at cycle t -> en_o=1 at t+1 carrying that pixel; no transfer -> en_o=0 at t+1.
REQ-024 S field = pixel(x,y,z); Sne field = pixel(x+1,y-1,z) from RAM.
REQ-025 Sne SHALL be forced 0 when y=0 or x=Nx-1 (covers Nx=1).
REQ-026 Transfer of pixel (Nx-1,Ny-1,Nz-1): FSM returns to IDLE next cycle, done_o pulses at t+1 together with final en_o.
REQ-027 start_i during RUN ignored, no cfg_err_o.
REQ-028 data_o holds last value when en_o=0; fields above DATA_WIDTH are 0.
REQ-029 busy_o = (state==RUN).

Reset
REQ-030 On rst_n low: state IDLE, counters/addr 0, data_o 0, en_o 0, done_o 0, cfg_err_o 0, pix_ready_o 0, stored Nx/Ny/Nz 0.
REQ-031 Reset mid-frame abandons frame; line RAM contents not cleared (unused since next frame starts at y=0).
REQ-032 First start_i after reset release accepted in the cycle it is asserted.

Structure
REQ-033 Shared package holds state enum (IDLE, RUN) and packed-word field positions (SNE_MSB=31, SNE_LSB=16, S_MSB=15, S_LSB=0), reused by the receiver.
REQ-034 One sub-module line_ram: simple dual-port, 1 write + 1 synchronous read port, LINE_DEPTH x DATA_WIDTH, 1-cycle read latency.

Verification
REQ-035 Nx=4,Ny=2,Nz=1, pixels 1..8 continuous: words 0x00000001,0x00000002,0x00000003,0x00000004,0x00020005,0x00030006,0x00040007,0x00000008; done_o with last.
REQ-036 Nx=2,Ny=2,Nz=2, pixels 10..17: y=1,z=0 word for 14 has Sne=11; z=1 word for 16 has Sne=13; x=1 words Sne=0.
REQ-037 Same as REQ-035 with pix_valid_i low every other cycle: identical word sequence, en_o gaps match valid gaps, latency 1.
REQ-038 start_i with Nx=64,Nz=64 (4096>2048): cfg_err_o pulse, busy_o stays 0, pix_ready_o 0.
REQ-039 rst_n low after 3 transfers of a frame: all outputs 0 next cycle; new start_i frame reproduces REQ-035 output.
REQ-040 Nx=1,Ny=3,Nz=1, pixels 5,6,7: words 0x00000005,0x00000006,0x00000007; start_i mid-frame ignored.

Source files
------------

// File: rtl/pixel_send_pkg.sv
// Shared definitions for the pixel sender and its matching receiver:
// FSM state encoding and bit positions of the packed {Sne, S} output word.
package pixel_send_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int FIELD_W = 16;
    localparam int SNE_MSB = 31;
    localparam int SNE_LSB = 16;
    localparam int S_MSB   = 15;
    localparam int S_LSB   = 0;

endpackage

// File: rtl/pixel_send_line_ram.sv
// Simple dual-port line buffer: one write port and one synchronous read
// port with single-cycle read latency.
module pixel_send_line_ram #(
    parameter int DEPTH  = 2048,
    parameter int WIDTH  = 12,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; stale contents
    // are never observed because each frame writes a row before reading it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixel_send.sv
// Streams a raw x/z/y-ordered frame and emits each sample packed with its
// north-east neighbour (x+1, y-1, same z) taken from a one-row line buffer.
module pixel_send
    import pixel_send_pkg::*;
#(
    parameter int X_LEN      = 11,
    parameter int Y_LEN      = 5,
    parameter int Z_LEN      = 8,
    parameter int DATA_WIDTH = 12,
    parameter int LINE_DEPTH = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [X_LEN-1:0]      Nx,
    input  logic [Y_LEN-1:0]      Ny,
    input  logic [Z_LEN-1:0]      Nz,
    input  logic [DATA_WIDTH-1:0] pix_i,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    output logic [31:0]           data_o,
    output logic                  en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o
);

    localparam int ADDR_W = $clog2(LINE_DEPTH);

    state_t state_q, state_d;

    logic [X_LEN-1:0]      nx_q, x_q;
    logic [Y_LEN-1:0]      ny_q, y_q;
    logic [Z_LEN-1:0]      nz_q, z_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [FIELD_W-1:0]    s_q;
    logic                  sne_zero_q;
    logic [DATA_WIDTH-1:0] rd_data;

    logic        xfer, x_last, z_last, y_last, frame_last;
    logic        accept, cfg_err_d;
    logic [31:0] frame_words;

    assign pix_ready_o = (state_q == RUN);
    assign busy_o      = (state_q == RUN);
    assign xfer        = pix_valid_i & pix_ready_o;

    assign x_last     = (x_q == nx_q - 1'b1);
    assign z_last     = (z_q == nz_q - 1'b1);
    assign y_last     = (y_q == ny_q - 1'b1);
    assign frame_last = x_last & z_last & y_last;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        cfg_err_d   = 1'b0;
        frame_words = 32'(Nx) * 32'(Nz);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (frame_words >= 32'd1 && frame_words <= 32'(LINE_DEPTH) && Ny != '0) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer && frame_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nx_q       <= '0;
            ny_q       <= '0;
            nz_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            addr_q     <= '0;
            s_q        <= '0;
            sne_zero_q <= 1'b1;
            en_o       <= 1'b0;
            done_o     <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_o      <= xfer;
            done_o    <= xfer & frame_last;
            cfg_err_o <= cfg_err_d;

            if (accept) begin
                nx_q   <= Nx;
                ny_q   <= Ny;
                nz_q   <= Nz;
                x_q    <= '0;
                y_q    <= '0;
                z_q    <= '0;
                addr_q <= '0;
            end else if (xfer) begin
                if (x_last) begin
                    x_q <= '0;
                    if (z_last) begin
                        z_q    <= '0;
                        addr_q <= '0;
                        y_q    <= y_last ? '0 : y_q + 1'b1;
                    end else begin
                        z_q    <= z_q + 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end else begin
                    x_q    <= x_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
            end

            // No previous row or no right neighbour: the stored sample is stale.
            if (xfer) begin
                s_q        <= FIELD_W'(pix_i);
                sne_zero_q <= (y_q == '0) | x_last;
            end
        end
    end

    // addr+1 is read before this cycle overwrites addr, so it still holds row y-1.
    pixel_send_line_ram #(
        .DEPTH (LINE_DEPTH),
        .WIDTH (DATA_WIDTH),
        .ADDR_W(ADDR_W)
    ) u_line_ram (
        .clk  (clk),
        .we   (xfer),
        .waddr(addr_q),
        .wdata(pix_i),
        .re   (xfer),
        .raddr(addr_q + 1'b1),
        .rdata(rd_data)
    );

    always_comb begin
        data_o                  = '0;
        data_o[S_MSB:S_LSB]     = s_q;
        data_o[SNE_MSB:SNE_LSB] = sne_zero_q ? '0 : FIELD_W'(rd_data);
    end

endmodule

// File: tb/tb_pixel_send.sv
// Directed bench for pixel_send: hand-computed packed words per transfer,
// plus config rejection, mid-frame reset and mid-frame start cases.
module tb_pixel_send;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [10:0] Nx;
    logic [4:0]  Ny;
    logic [7:0]  Nz;
    logic [11:0] pix_i;
    logic        pix_valid_i;
    logic        pix_ready_o;
    logic [31:0] data_o;
    logic        en_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;

    int total = 0;
    int bad   = 0;

    pixel_send dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .Nx         (Nx),
        .Ny         (Ny),
        .Nz         (Nz),
        .pix_i      (pix_i),
        .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o),
        .data_o     (data_o),
        .en_o       (en_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cfg_err_o  (cfg_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " data_o"}, data_o, 32'h0);
        check({tag, " en_o"}, {31'b0, en_o}, 32'h0);
        check({tag, " done_o"}, {31'b0, done_o}, 32'h0);
        check({tag, " cfg_err_o"}, {31'b0, cfg_err_o}, 32'h0);
        check({tag, " busy_o"}, {31'b0, busy_o}, 32'h0);
        check({tag, " pix_ready_o"}, {31'b0, pix_ready_o}, 32'h0);
    endtask

    // Runs one whole frame of consecutive pixel values starting at base.
    // gaps inserts an idle cycle after each transfer; mid_start (>=0) raises
    // start_i with different dimensions alongside that pixel index.
    task automatic run_frame(input string tag, input int nx, input int ny, input int nz,
                             input int base, input logic [31:0] exp_words [8],
                             input bit gaps, input int mid_start);
        int n;
        n = nx * ny * nz;
        Nx = 11'(nx);
        Ny = 5'(ny);
        Nz = 8'(nz);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check({tag, " busy after start"}, {31'b0, busy_o}, 32'h1);
        check({tag, " ready after start"}, {31'b0, pix_ready_o}, 32'h1);
        check({tag, " no cfg_err"}, {31'b0, cfg_err_o}, 32'h0);
        for (int i = 0; i < n; i++) begin
            pix_i       = 12'(base + i);
            pix_valid_i = 1'b1;
            if (i == mid_start) begin
                start_i = 1'b1;
                Nx      = 11'd7;
                Nz      = 8'd3;
            end
            step();
            start_i     = 1'b0;
            pix_valid_i = 1'b0;
            check($sformatf("%s word %0d", tag, i), data_o, exp_words[i]);
            check($sformatf("%s en %0d", tag, i), {31'b0, en_o}, 32'h1);
            check($sformatf("%s done %0d", tag, i), {31'b0, done_o}, (i == n - 1) ? 32'h1 : 32'h0);
            check($sformatf("%s cfg_err %0d", tag, i), {31'b0, cfg_err_o}, 32'h0);
            if (gaps && i != n - 1) begin
                step();
                check($sformatf("%s gap en %0d", tag, i), {31'b0, en_o}, 32'h0);
                check($sformatf("%s gap hold %0d", tag, i), data_o, exp_words[i]);
            end
        end
        check({tag, " busy after last"}, {31'b0, busy_o}, 32'h0);
        check({tag, " ready after last"}, {31'b0, pix_ready_o}, 32'h0);
        step();
        check({tag, " en low after frame"}, {31'b0, en_o}, 32'h0);
        check({tag, " done one cycle"}, {31'b0, done_o}, 32'h0);
    endtask

    logic [31:0] exp_a [8];
    logic [31:0] exp_b [8];
    logic [31:0] exp_c [8];

    initial begin
        exp_a = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
                  32'h00020005, 32'h00030006, 32'h00040007, 32'h00000008};
        exp_b = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D,
                  32'h000B000E, 32'h0000000F, 32'h000D0010, 32'h00000011};
        exp_c = '{32'h00000005, 32'h00000006, 32'h00000007, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0};

        rst_n       = 1'b0;
        start_i     = 1'b0;
        Nx          = '0;
        Ny          = '0;
        Nz          = '0;
        pix_i       = '0;
        pix_valid_i = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // 4x2x1 frame, continuous valid
        run_frame("A", 4, 2, 1, 1, exp_a, 1'b0, -1);

        // 2x2x2 frame: neighbour comes from the matching z plane of row y-1
        run_frame("B", 2, 2, 2, 10, exp_b, 1'b0, -1);

        // 4x2x1 frame with valid low every other cycle
        run_frame("A_gaps", 4, 2, 1, 1, exp_a, 1'b1, -1);

        // 64*64 exceeds the line buffer: rejected
        Nx      = 11'd64;
        Ny      = 5'd1;
        Nz      = 8'd64;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("oversize cfg_err", {31'b0, cfg_err_o}, 32'h1);
        check("oversize busy", {31'b0, busy_o}, 32'h0);
        check("oversize ready", {31'b0, pix_ready_o}, 32'h0);
        step();
        check("oversize cfg_err pulse", {31'b0, cfg_err_o}, 32'h0);
        check("oversize still idle", {31'b0, busy_o}, 32'h0);

        // Ny = 0 is rejected as well
        Nx      = 11'd4;
        Ny      = 5'd0;
        Nz      = 8'd1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("ny0 cfg_err", {31'b0, cfg_err_o}, 32'h1);
        check("ny0 busy", {31'b0, busy_o}, 32'h0);
        step();

        // Reset after three transfers abandons the frame
        Nx      = 11'd4;
        Ny      = 5'd2;
        Nz      = 8'd1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_i       = 12'(1 + i);
            pix_valid_i = 1'b1;
            step();
        end
        check("pre-reset word", data_o, 32'h00000003);
        pix_valid_i = 1'b0;
        rst_n       = 1'b0;
        step();
        check_idle_outputs("mid-frame reset");
        rst_n = 1'b1;
        step();
        run_frame("A_after_reset", 4, 2, 1, 1, exp_a, 1'b0, -1);

        // Nx=1: neighbour always forced to zero; start_i mid-frame ignored
        run_frame("C", 1, 3, 1, 5, exp_c, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
